// File: rtl/hil_step_scheduler.sv
// HIL plant step sequencer: prescaled tick -> en_elec -> settle -> en_mech -> settle -> sample handshake.
// Optional build macro HIL_SCHED_STEP_LIMIT_EN adds step_limit/done to stop after a fixed number of steps.
module hil_step_scheduler #(
    parameter int N_BITS_DIV    = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int N_BITS_STEP   = 32
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   run,
    input  logic                   single,
    input  logic [N_BITS_DIV-1:0]  div,
    input  logic                   clear_ovr,
    output logic                   en_elec,
    output logic                   en_mech,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic [N_BITS_STEP-1:0] step_count,
    output logic                   busy,
`ifdef HIL_SCHED_STEP_LIMIT_EN
    output logic                   overrun,
    input  logic [N_BITS_STEP-1:0] step_limit,
    output logic                   done
`else
    output logic                   overrun
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ELEC   = 3'd1;
    localparam logic [2:0] S_SET_E  = 3'd2;
    localparam logic [2:0] S_MECH   = 3'd3;
    localparam logic [2:0] S_SET_M  = 3'd4;
    localparam logic [2:0] S_SAMPLE = 3'd5;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [N_BITS_DIV-1:0] cnt;
    logic [3:0]            settle_cnt;
    logic                  settle_last;
    logic                  run_gated;
    logic                  single_gated;
    logic                  tick;
    logic                  request;
    logic                  handshake;

    assign handshake = sample_valid && sample_ready;

`ifdef HIL_SCHED_STEP_LIMIT_EN
    logic [N_BITS_STEP-1:0] step_limit_q;

    // Once the limit is reached, both request sources are blocked until the limit is rewritten.
    assign run_gated    = run & ~done;
    assign single_gated = single & ~done;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            done         <= 1'b0;
            step_limit_q <= '0;
        end else begin
            step_limit_q <= step_limit;
            if (step_limit != step_limit_q) begin
                done <= 1'b0;
            end else if (handshake && (step_limit != '0) &&
                         ((step_count + N_BITS_STEP'(1)) == step_limit)) begin
                done <= 1'b1;
            end
        end
    end
`else
    assign run_gated    = run;
    assign single_gated = single;
`endif

    assign tick        = run_gated && (cnt == div);
    assign request     = tick || (single_gated && !run_gated);
    assign settle_last = (settle_cnt == SETTLE_LAST);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (!run_gated || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (request) state_next = S_ELEC;
            S_ELEC:   state_next = S_SET_E;
            S_SET_E:  if (settle_last) state_next = S_MECH;
            S_MECH:   state_next = S_SET_M;
            S_SET_M:  if (settle_last) state_next = S_SAMPLE;
            S_SAMPLE: if (handshake) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            settle_cnt <= '0;
        end else if (((state == S_SET_E) || (state == S_SET_M)) && !settle_last) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // Outputs are registered from the next state so they are glitch-free and line up with the state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= S_IDLE;
            en_elec      <= 1'b0;
            en_mech      <= 1'b0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            en_elec      <= (state_next == S_ELEC);
            en_mech      <= (state_next == S_MECH);
            sample_valid <= (state_next == S_SAMPLE);
            busy         <= (state_next != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            step_count <= '0;
        end else if (handshake) begin
            step_count <= step_count + 1'b1;
        end
    end

    // A tick that finds the sequencer busy is dropped; setting takes priority over clearing.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            overrun <= 1'b0;
        end else if (tick && (state != S_IDLE)) begin
            overrun <= 1'b1;
        end else if (clear_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hil_step_scheduler.sv
// Self-checking bench for hil_step_scheduler: expected event cycles are queued when stimulus is
// driven and compared against events the monitor records from the DUT (S = SETTLE_CYCLES = 2).
module tb_hil_step_scheduler;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        run = 1'b0;
    logic        single = 1'b0;
    logic [15:0] div = 16'd0;
    logic        clear_ovr = 1'b0;
    logic        sample_ready = 1'b0;
    logic        en_elec;
    logic        en_mech;
    logic        sample_valid;
    logic [31:0] step_count;
    logic        busy;
    logic        overrun;
`ifdef HIL_SCHED_STEP_LIMIT_EN
    logic [31:0] step_limit = 32'd0;
    logic        done;
`endif

    int cyc = 0;
    int n_compared = 0;
    int n_mismatched = 0;
    int both_high = 0;
    logic valid_prev = 1'b0;

    int obs_elec[$];
    int obs_mech[$];
    int obs_vrise[$];
    int obs_hs[$];
    int exp_elec[$];
    int exp_mech[$];
    int exp_vrise[$];

    hil_step_scheduler #(
        .N_BITS_DIV   (16),
        .SETTLE_CYCLES(2),
        .N_BITS_STEP  (32)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .run         (run),
        .single      (single),
        .div         (div),
        .clear_ovr   (clear_ovr),
        .en_elec     (en_elec),
        .en_mech     (en_mech),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .step_count  (step_count),
        .busy        (busy),
`ifdef HIL_SCHED_STEP_LIMIT_EN
        .overrun     (overrun),
        .step_limit  (step_limit),
        .done        (done)
`else
        .overrun     (overrun)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle number of every DUT event, sampled mid-cycle.
    always @(negedge clk) begin
        if (en_elec) obs_elec.push_back(cyc);
        if (en_mech) obs_mech.push_back(cyc);
        if (sample_valid && !valid_prev) obs_vrise.push_back(cyc);
        if (sample_valid && sample_ready) obs_hs.push_back(cyc);
        if (en_elec && en_mech) both_high++;
        valid_prev = sample_valid;
    end

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_queues();
        obs_elec.delete();
        obs_mech.delete();
        obs_vrise.delete();
        obs_hs.delete();
        exp_elec.delete();
        exp_mech.delete();
        exp_vrise.delete();
    endtask

    task automatic do_reset(output int r);
        nrst = 1'b0;
        single = 1'b0;
        clear_ovr = 1'b0;
        goto_cycle(cyc + 3);
        clear_queues();
        nrst = 1'b1;
        r = cyc;
    endtask

    task automatic test_reset();
        int r, e, o;
        run = 1'b1;
        div = 16'd3;
        sample_ready = 1'b1;
        nrst = 1'b0;
        clear_queues();
        for (int i = 0; i < 4; i++) begin
            goto_cycle(cyc + 1);
            @(negedge clk);
            n_compared++;
            if ({en_elec, en_mech, sample_valid, busy, overrun} !== 5'b0 || step_count !== 32'd0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_outputs: got flags=%b count=%0d, expected flags=00000 count=0",
                         {en_elec, en_mech, sample_valid, busy, overrun}, step_count);
            end
        end
        n_compared++;
        if (obs_elec.size() + obs_mech.size() + obs_vrise.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_no_pulses: got %0d events, expected 0",
                     obs_elec.size() + obs_mech.size() + obs_vrise.size());
        end
        goto_cycle(cyc + 1);
        nrst = 1'b1;
        r = cyc;
        exp_elec.push_back(r + 4);
        exp_mech.push_back(r + 7);
        exp_vrise.push_back(r + 10);
        goto_cycle(r + 11);
        run = 1'b0;
        goto_cycle(r + 25);
        while (exp_elec.size() > 0) begin
            e = exp_elec.pop_front();
            n_compared++;
            o = (obs_elec.size() > 0) ? obs_elec.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL reset_en_elec_cycle: got %0d, expected %0d", o, e);
            end
        end
        while (exp_mech.size() > 0) begin
            e = exp_mech.pop_front();
            n_compared++;
            o = (obs_mech.size() > 0) ? obs_mech.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL reset_en_mech_cycle: got %0d, expected %0d", o, e);
            end
        end
        while (exp_vrise.size() > 0) begin
            e = exp_vrise.pop_front();
            n_compared++;
            o = (obs_vrise.size() > 0) ? obs_vrise.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL reset_valid_cycle: got %0d, expected %0d", o, e);
            end
        end
    endtask

    task automatic test_free_run();
        int r, e, o;
        run = 1'b1;
        div = 16'd7;
        sample_ready = 1'b1;
        do_reset(r);
        for (int k = 0; k < 5; k++) begin
            exp_elec.push_back(r + 8 + 8 * k);
            exp_mech.push_back(r + 11 + 8 * k);
            exp_vrise.push_back(r + 14 + 8 * k);
        end
        goto_cycle(r + 40);
        run = 1'b0;
        goto_cycle(r + 55);
        @(negedge clk);
        while (exp_elec.size() > 0) begin
            e = exp_elec.pop_front();
            n_compared++;
            o = (obs_elec.size() > 0) ? obs_elec.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL free_run_en_elec: got %0d, expected %0d", o, e);
            end
        end
        n_compared++;
        if (obs_elec.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL free_run_extra_elec: got %0d extra, expected 0", obs_elec.size());
        end
        while (exp_mech.size() > 0) begin
            e = exp_mech.pop_front();
            n_compared++;
            o = (obs_mech.size() > 0) ? obs_mech.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL free_run_en_mech: got %0d, expected %0d", o, e);
            end
        end
        while (exp_vrise.size() > 0) begin
            e = exp_vrise.pop_front();
            n_compared++;
            o = (obs_vrise.size() > 0) ? obs_vrise.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL free_run_valid: got %0d, expected %0d", o, e);
            end
        end
        n_compared++;
        if (step_count !== 32'd5 || overrun !== 1'b0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL free_run_status: got count=%0d ovr=%b busy=%b, expected count=5 ovr=0 busy=0",
                     step_count, overrun, busy);
        end
    endtask

    task automatic test_overrun();
        int r, e, o;
        run = 1'b1;
        div = 16'd6;
        sample_ready = 1'b1;
        do_reset(r);
        exp_elec.push_back(r + 7);
        exp_elec.push_back(r + 21);
        goto_cycle(r + 13);
        @(negedge clk);
        n_compared++;
        if (overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_before_tick: got %b, expected 0", overrun);
        end
        goto_cycle(r + 14);
        @(negedge clk);
        n_compared++;
        if (overrun !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_set: got %b, expected 1", overrun);
        end
        goto_cycle(r + 16);
        clear_ovr = 1'b1;
        goto_cycle(r + 17);
        clear_ovr = 1'b0;
        @(negedge clk);
        n_compared++;
        if (overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_clear: got %b, expected 0", overrun);
        end
        goto_cycle(r + 27);
        clear_ovr = 1'b1;
        @(negedge clk);
        n_compared++;
        if (overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_pre_collision: got %b, expected 0", overrun);
        end
        goto_cycle(r + 28);
        clear_ovr = 1'b0;
        run = 1'b0;
        @(negedge clk);
        n_compared++;
        if (overrun !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_set_wins: got %b, expected 1", overrun);
        end
        goto_cycle(r + 40);
        while (exp_elec.size() > 0) begin
            e = exp_elec.pop_front();
            n_compared++;
            o = (obs_elec.size() > 0) ? obs_elec.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL overrun_en_elec: got %0d, expected %0d", o, e);
            end
        end
        n_compared++;
        if (obs_elec.size() != 0 || step_count !== 32'd2) begin
            n_mismatched++;
            $display("[TB] FAIL overrun_skipped_step: got extra=%0d count=%0d, expected extra=0 count=2",
                     obs_elec.size(), step_count);
        end
    endtask

    task automatic test_single_hold();
        int r, a, e, o;
        run = 1'b0;
        div = 16'd0;
        sample_ready = 1'b0;
        do_reset(r);
        a = r + 2;
        goto_cycle(a);
        single = 1'b1;
        exp_elec.push_back(a + 1);
        exp_mech.push_back(a + 4);
        exp_vrise.push_back(a + 7);
        goto_cycle(a + 1);
        single = 1'b0;
        goto_cycle(a + 3);
        single = 1'b1;
        goto_cycle(a + 4);
        single = 1'b0;
        for (int c = a + 7; c <= a + 16; c++) begin
            goto_cycle(c);
            @(negedge clk);
            n_compared++;
            if (sample_valid !== 1'b1 || step_count !== 32'd0) begin
                n_mismatched++;
                $display("[TB] FAIL single_hold_c%0d: got valid=%b count=%0d, expected valid=1 count=0",
                         c - a, sample_valid, step_count);
            end
        end
        goto_cycle(a + 17);
        sample_ready = 1'b1;
        goto_cycle(a + 18);
        sample_ready = 1'b0;
        @(negedge clk);
        n_compared++;
        if (step_count !== 32'd1 || busy !== 1'b0 || sample_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL single_after_ready: got count=%0d busy=%b valid=%b, expected 1 0 0",
                     step_count, busy, sample_valid);
        end
        goto_cycle(a + 25);
        while (exp_elec.size() > 0) begin
            e = exp_elec.pop_front();
            n_compared++;
            o = (obs_elec.size() > 0) ? obs_elec.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL single_en_elec: got %0d, expected %0d", o, e);
            end
        end
        while (exp_mech.size() > 0) begin
            e = exp_mech.pop_front();
            n_compared++;
            o = (obs_mech.size() > 0) ? obs_mech.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL single_en_mech: got %0d, expected %0d", o, e);
            end
        end
        while (exp_vrise.size() > 0) begin
            e = exp_vrise.pop_front();
            n_compared++;
            o = (obs_vrise.size() > 0) ? obs_vrise.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL single_valid: got %0d, expected %0d", o, e);
            end
        end
        n_compared++;
        o = (obs_hs.size() > 0) ? obs_hs.pop_front() : -1;
        if (o !== a + 17 || obs_hs.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL single_handshake: got %0d (+%0d more), expected %0d", o, obs_hs.size(), a + 17);
        end
        n_compared++;
        if (obs_elec.size() != 0 || overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL single_busy_ignored: got extra=%0d ovr=%b, expected extra=0 ovr=0",
                     obs_elec.size(), overrun);
        end
    endtask

    task automatic test_single_while_run();
        int r;
        run = 1'b1;
        div = 16'd200;
        sample_ready = 1'b1;
        do_reset(r);
        goto_cycle(r + 2);
        single = 1'b1;
        goto_cycle(r + 3);
        single = 1'b0;
        goto_cycle(r + 12);
        @(negedge clk);
        n_compared++;
        if (obs_elec.size() != 0 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL single_run_ignored: got elec=%0d busy=%b, expected elec=0 busy=0",
                     obs_elec.size(), busy);
        end
        run = 1'b0;
    endtask

    task automatic test_run_drop_and_reset();
        int r, e, o;
        run = 1'b1;
        div = 16'd4;
        sample_ready = 1'b1;
        do_reset(r);
        exp_elec.push_back(r + 5);
        exp_mech.push_back(r + 8);
        goto_cycle(r + 6);
        run = 1'b0;
        goto_cycle(r + 20);
        while (exp_elec.size() > 0) begin
            e = exp_elec.pop_front();
            n_compared++;
            o = (obs_elec.size() > 0) ? obs_elec.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL run_drop_en_elec: got %0d, expected %0d", o, e);
            end
        end
        while (exp_mech.size() > 0) begin
            e = exp_mech.pop_front();
            n_compared++;
            o = (obs_mech.size() > 0) ? obs_mech.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL run_drop_en_mech: got %0d, expected %0d", o, e);
            end
        end
        n_compared++;
        if (obs_elec.size() != 0 || step_count !== 32'd1 || obs_vrise.size() != 1) begin
            n_mismatched++;
            $display("[TB] FAIL run_drop_completion: got extra=%0d count=%0d valids=%0d, expected 0 1 1",
                     obs_elec.size(), step_count, obs_vrise.size());
        end

        run = 1'b1;
        do_reset(r);
        goto_cycle(r + 9);
        nrst = 1'b0;
        run = 1'b0;
        goto_cycle(r + 10);
        @(negedge clk);
        n_compared++;
        if (busy !== 1'b0 || en_mech !== 1'b0 || sample_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_step_abort: got busy=%b mech=%b valid=%b, expected 0 0 0",
                     busy, en_mech, sample_valid);
        end
        goto_cycle(r + 12);
        nrst = 1'b1;
        goto_cycle(r + 25);
        n_compared++;
        if (obs_elec.size() != 1 || obs_mech.size() != 1 || obs_vrise.size() != 0 || step_count !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_step_events: got elec=%0d mech=%0d valid=%0d count=%0d, expected 1 1 0 0",
                     obs_elec.size(), obs_mech.size(), obs_vrise.size(), step_count);
        end
    endtask

    task automatic test_back_to_back();
        int r, e, o;
        run = 1'b1;
        div = 16'd0;
        sample_ready = 1'b1;
        do_reset(r);
        for (int k = 0; k < 3; k++) begin
            exp_elec.push_back(r + 1 + 8 * k);
            exp_mech.push_back(r + 4 + 8 * k);
        end
        goto_cycle(r + 18);
        run = 1'b0;
        goto_cycle(r + 35);
        while (exp_elec.size() > 0) begin
            e = exp_elec.pop_front();
            n_compared++;
            o = (obs_elec.size() > 0) ? obs_elec.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_en_elec: got %0d, expected %0d", o, e);
            end
        end
        while (exp_mech.size() > 0) begin
            e = exp_mech.pop_front();
            n_compared++;
            o = (obs_mech.size() > 0) ? obs_mech.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_en_mech: got %0d, expected %0d", o, e);
            end
        end
        n_compared++;
        if (step_count !== 32'd3 || overrun !== 1'b1 || obs_elec.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_status: got count=%0d ovr=%b extra=%0d, expected 3 1 0",
                     step_count, overrun, obs_elec.size());
        end
    endtask

`ifdef HIL_SCHED_STEP_LIMIT_EN
    task automatic test_step_limit();
        int r, e, o;
        run = 1'b1;
        div = 16'd15;
        sample_ready = 1'b1;
        step_limit = 32'd3;
        do_reset(r);
        exp_elec.push_back(r + 16);
        exp_elec.push_back(r + 32);
        exp_elec.push_back(r + 48);
        exp_elec.push_back(r + 107);
        goto_cycle(r + 89);
        @(negedge clk);
        n_compared++;
        if (done !== 1'b1 || step_count !== 32'd3 || obs_elec.size() != 3) begin
            n_mismatched++;
            $display("[TB] FAIL limit_reached: got done=%b count=%0d elec=%0d, expected 1 3 3",
                     done, step_count, obs_elec.size());
        end
        goto_cycle(r + 90);
        step_limit = 32'd4;
        goto_cycle(r + 91);
        @(negedge clk);
        n_compared++;
        if (done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL limit_rewrite_clears: got %b, expected 0", done);
        end
        goto_cycle(r + 130);
        while (exp_elec.size() > 0) begin
            e = exp_elec.pop_front();
            n_compared++;
            o = (obs_elec.size() > 0) ? obs_elec.pop_front() : -1;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL limit_en_elec: got %0d, expected %0d", o, e);
            end
        end
        n_compared++;
        if (done !== 1'b1 || step_count !== 32'd4 || obs_elec.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL limit_second_run: got done=%b count=%0d extra=%0d, expected 1 4 0",
                     done, step_count, obs_elec.size());
        end
        run = 1'b0;
        step_limit = 32'd0;
    endtask
`endif

    task automatic test_exclusive_enables();
        n_compared++;
        if (both_high != 0) begin
            n_mismatched++;
            $display("[TB] FAIL enables_exclusive: got %0d overlapping cycles, expected 0", both_high);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_free_run();
        test_overrun();
        test_single_hold();
        test_single_while_run();
        test_run_drop_and_reset();
        test_back_to_back();
`ifdef HIL_SCHED_STEP_LIMIT_EN
        test_step_limit();
`endif
        test_exclusive_enables();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
